// File: rtl/tlb_op_ctrl_pkg.sv
// Shared op and controller-state encodings for the TLB maintenance sequencer.
// Also holds the legality check used when an op is accepted.
package tlb_op_ctrl_pkg;

    typedef enum logic [2:0] {
        TLB_OP_SRCH = 3'd1,
        TLB_OP_RD   = 3'd2,
        TLB_OP_WR   = 3'd3,
        TLB_OP_FILL = 3'd4,
        TLB_OP_INV  = 3'd5
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } ctrl_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == TLB_OP_SRCH) || (op == TLB_OP_RD) || (op == TLB_OP_WR) ||
               (op == TLB_OP_FILL) || (op == TLB_OP_INV);
    endfunction

endpackage

// File: rtl/tlb_rand_idx.sv
// Free-running TLBFILL index: counts 0..TLBNUM-1 and wraps, holding while i_hold is high.
module tlb_rand_idx #(
    parameter int TLBNUM = 32,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_hold,
    output logic [IDXW-1:0] o_index
);

    logic [IDXW-1:0] r_index;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index <= '0;
        end else if (!i_hold) begin
            r_index <= (r_index == IDXW'(TLBNUM - 1)) ? '0 : r_index + 1'b1;
        end
    end

    assign o_index = r_index;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences one TLB maintenance op at a time onto addr_trans: blocks and drains translations,
// fires the single TLB strobe, collects search results and reports completion to the pipeline.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM = 32,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            excp_flush,
    input  logic            ertn_flush,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_type,
    input  logic [4:0]      inv_op_i,
    input  logic [9:0]      inv_asid_i,
    input  logic [18:0]     inv_vpn_i,
    input  logic            trans_busy,
    output logic            trans_block,
    output logic            srch_en,
    input  logic            srch_finish,
    input  logic            srch_found,
    input  logic [IDXW-1:0] srch_index,
    output logic            tlb_wen,
    output logic            fill_en,
    output logic [IDXW-1:0] rand_index,
    output logic            tlbinv_en,
    output logic [4:0]      tlbinv_op,
    output logic [9:0]      tlbinv_asid,
    output logic [18:0]     tlbinv_vpn,
    output logic            csr_we,
    output logic [2:0]      csr_op,
    output logic            csr_found,
    output logic [IDXW-1:0] csr_index,
    output logic            op_done
);

    ctrl_state_e     r_state;
    logic [2:0]      r_op;
    logic [4:0]      r_inv_op;
    logic [9:0]      r_inv_asid;
    logic [18:0]     r_inv_vpn;
    logic            r_csr_found;
    logic [IDXW-1:0] r_csr_index;

    logic w_flush;
    logic w_kill;
    logic w_exec;
    logic w_resp;
    logic w_rand_hold;

    assign w_flush = excp_flush | ertn_flush;
    assign w_kill  = w_flush | reset;
    assign w_exec  = (r_state == ST_EXEC);
    assign w_resp  = (r_state == ST_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_inv_op    <= '0;
            r_inv_asid  <= '0;
            r_inv_vpn   <= '0;
            r_csr_found <= 1'b0;
            r_csr_index <= '0;
        end else if (w_flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        r_op       <= op_type;
                        r_inv_op   <= inv_op_i;
                        r_inv_asid <= inv_asid_i;
                        r_inv_vpn  <= inv_vpn_i;
                        r_state    <= is_legal_op(op_type) ? ST_DRAIN : ST_RESP;
                    end
                end
                ST_DRAIN: begin
                    if (!trans_busy) r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_state <= (r_op == TLB_OP_SRCH) ? ST_WAIT : ST_RESP;
                end
                ST_WAIT: begin
                    if (srch_finish) begin
                        r_csr_found <= srch_found;
                        r_csr_index <= srch_index;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: flush/reset must suppress side effects in the same cycle, so strobes are
    // decoded from the registered state and gated combinationally rather than registered.
    assign srch_en   = !w_kill && w_exec && (r_op == TLB_OP_SRCH);
    assign tlb_wen   = !w_kill && w_exec && (r_op == TLB_OP_WR);
    assign fill_en   = !w_kill && w_exec && (r_op == TLB_OP_FILL);
    assign tlbinv_en = !w_kill && w_exec && (r_op == TLB_OP_INV);
    assign csr_we    = !w_kill && ((w_exec && (r_op == TLB_OP_RD)) ||
                                   (w_resp && (r_op == TLB_OP_SRCH)));
    assign csr_op    = csr_we ? r_op : 3'd0;
    assign op_done   = !w_kill && w_resp;

    assign op_ready    = (r_state == ST_IDLE);
    assign trans_block = (r_state == ST_DRAIN) || w_exec || (r_state == ST_WAIT);

    assign tlbinv_op   = r_inv_op;
    assign tlbinv_asid = r_inv_asid;
    assign tlbinv_vpn  = r_inv_vpn;
    assign csr_found   = r_csr_found;
    assign csr_index   = r_csr_index;

    // The fill index must stay put for the cycle the FILL strobe consumes it.
    assign w_rand_hold = w_exec && (r_op == TLB_OP_FILL);

    tlb_rand_idx #(
        .TLBNUM(TLBNUM),
        .IDXW  (IDXW)
    ) u_rand_idx (
        .clk    (clk),
        .reset  (reset),
        .i_hold (w_rand_hold),
        .o_index(rand_index)
    );

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: cycle-stamped transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with flushes and resets.
module tb_tlb_op_ctrl;

    localparam int TLBNUM = 32;
    localparam int IDXW   = 5;

    logic            clk;
    logic            reset;
    logic            excp_flush;
    logic            ertn_flush;
    logic            op_valid;
    logic            op_ready;
    logic [2:0]      op_type;
    logic [4:0]      inv_op_i;
    logic [9:0]      inv_asid_i;
    logic [18:0]     inv_vpn_i;
    logic            trans_busy;
    logic            trans_block;
    logic            srch_en;
    logic            srch_finish;
    logic            srch_found;
    logic [IDXW-1:0] srch_index;
    logic            tlb_wen;
    logic            fill_en;
    logic [IDXW-1:0] rand_index;
    logic            tlbinv_en;
    logic [4:0]      tlbinv_op;
    logic [9:0]      tlbinv_asid;
    logic [18:0]     tlbinv_vpn;
    logic            csr_we;
    logic [2:0]      csr_op;
    logic            csr_found;
    logic [IDXW-1:0] csr_index;
    logic            op_done;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
        .inv_op_i(inv_op_i), .inv_asid_i(inv_asid_i), .inv_vpn_i(inv_vpn_i),
        .trans_busy(trans_busy), .trans_block(trans_block),
        .srch_en(srch_en), .srch_finish(srch_finish), .srch_found(srch_found),
        .srch_index(srch_index), .tlb_wen(tlb_wen), .fill_en(fill_en),
        .rand_index(rand_index), .tlbinv_en(tlbinv_en), .tlbinv_op(tlbinv_op),
        .tlbinv_asid(tlbinv_asid), .tlbinv_vpn(tlbinv_vpn), .csr_we(csr_we),
        .csr_op(csr_op), .csr_found(csr_found), .csr_index(csr_index), .op_done(op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: an accepted op plus the absolute cycles at which it executes
    // and responds; those stamps are filled in as the gating inputs are observed.
    bit         chk_on = 1'b0;
    int         cyc = 0;
    bit         m_active = 1'b0;
    logic [2:0] m_op = '0;
    int         m_exec_at = -1;
    int         m_resp_at = -1;
    int         m_cnt = 0;
    logic [4:0] m_inv_op = '0;
    logic [9:0] m_inv_asid = '0;
    logic [18:0] m_inv_vpn = '0;
    logic       m_found = 1'b0;
    int         m_index = 0;

    always @(negedge clk) begin
        bit f, e_exec, e_resp, e_csr_we;
        f        = excp_flush | ertn_flush | reset;
        e_exec   = m_active && (cyc == m_exec_at) && !f;
        e_resp   = m_active && (cyc == m_resp_at) && !f;
        e_csr_we = (e_exec && m_op == 3'd2) || (e_resp && m_op == 3'd1);
        if (chk_on) begin
            check("op_ready",    op_ready,    !m_active);
            check("trans_block", trans_block, m_active && (cyc != m_resp_at));
            check("srch_en",     srch_en,     e_exec && m_op == 3'd1);
            check("tlb_wen",     tlb_wen,     e_exec && m_op == 3'd3);
            check("fill_en",     fill_en,     e_exec && m_op == 3'd4);
            check("tlbinv_en",   tlbinv_en,   e_exec && m_op == 3'd5);
            check("csr_we",      csr_we,      e_csr_we);
            check("csr_op",      csr_op,      e_csr_we ? m_op : 3'd0);
            check("op_done",     op_done,     e_resp);
            check("rand_index",  rand_index,  m_cnt);
            check("tlbinv_op",   tlbinv_op,   m_inv_op);
            check("tlbinv_asid", tlbinv_asid, m_inv_asid);
            check("tlbinv_vpn",  tlbinv_vpn,  m_inv_vpn);
            if (e_resp && m_op == 3'd1) begin
                check("csr_found", csr_found, m_found);
                check("csr_index", csr_index, m_index);
            end
        end
        if (reset) begin
            m_active = 1'b0; m_cnt = 0; m_op = '0;
            m_inv_op = '0; m_inv_asid = '0; m_inv_vpn = '0;
            m_found = 1'b0; m_index = 0;
        end else begin
            if (!(m_active && cyc == m_exec_at && m_op == 3'd4)) m_cnt = (m_cnt + 1) % TLBNUM;
            if (excp_flush || ertn_flush) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (op_valid) begin
                    m_active = 1'b1; m_op = op_type;
                    m_inv_op = inv_op_i; m_inv_asid = inv_asid_i; m_inv_vpn = inv_vpn_i;
                    m_exec_at = -1;
                    m_resp_at = (op_type >= 3'd1 && op_type <= 3'd5) ? -1 : cyc + 1;
                end
            end else if (cyc == m_resp_at) begin
                m_active = 1'b0;
            end else if (m_exec_at < 0) begin
                if (!trans_busy) m_exec_at = cyc + 1;
            end else if (cyc == m_exec_at) begin
                if (m_op != 3'd1) m_resp_at = cyc + 1;
            end else if (m_resp_at < 0 && srch_finish) begin
                m_found = srch_found; m_index = srch_index; m_resp_at = cyc + 1;
            end
        end
        cyc++;
    end

    typedef struct {
        logic srch_en, tlb_wen, fill_en, tlbinv_en, csr_we, op_done, trans_block, op_ready, csr_found;
        logic [2:0] csr_op;
        logic [IDXW-1:0] csr_index, rand_index;
        logic [4:0] inv_op;
        logic [9:0] inv_asid;
        logic [18:0] inv_vpn;
    } rec_t;

    rec_t rec[16];

    // Issues one op at cycle k=0 and records outputs for nrec cycles; trans_busy is high
    // for k < busy_until and excp_flush is high at k == flush_at.
    task automatic run_op(input logic [2:0] op, input int busy_until, input int flush_at, input int nrec);
        @(posedge clk); #1;
        op_valid = 1'b1; op_type = op;
        trans_busy = (busy_until > 0); excp_flush = (flush_at == 0);
        for (int k = 0; k < nrec; k++) begin
            @(negedge clk);
            rec[k].srch_en = srch_en;     rec[k].tlb_wen = tlb_wen;
            rec[k].fill_en = fill_en;     rec[k].tlbinv_en = tlbinv_en;
            rec[k].csr_we = csr_we;       rec[k].op_done = op_done;
            rec[k].trans_block = trans_block; rec[k].op_ready = op_ready;
            rec[k].csr_found = csr_found; rec[k].csr_op = csr_op;
            rec[k].csr_index = csr_index; rec[k].rand_index = rand_index;
            rec[k].inv_op = tlbinv_op;    rec[k].inv_asid = tlbinv_asid;
            rec[k].inv_vpn = tlbinv_vpn;
            @(posedge clk); #1;
            op_valid = 1'b0;
            trans_busy = (k + 1 < busy_until);
            excp_flush = (flush_at == k + 1);
        end
        trans_busy = 1'b0; excp_flush = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = op_ready;
        end
        check("wait_idle", seen, 1'b1);
    endtask

    initial begin
        reset = 1'b1; excp_flush = 1'b0; ertn_flush = 1'b0; op_valid = 1'b0; op_type = '0;
        inv_op_i = '0; inv_asid_i = '0; inv_vpn_i = '0; trans_busy = 1'b0;
        srch_finish = 1'b0; srch_found = 1'b0; srch_index = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; chk_on = 1'b1;

        @(negedge clk);
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_trans_block", trans_block, 1'b0);
        check("rst_op_done", op_done, 1'b0);
        check("rst_rand_index", rand_index, 0);
        check("rst_csr_found", csr_found, 1'b0);
        check("rst_tlbinv_vpn", tlbinv_vpn, 0);

        // SRCH hit: strobe at k=2, response at k=4.
        srch_finish = 1'b1; srch_found = 1'b1; srch_index = 5'd5;
        run_op(3'd1, 0, -1, 7);
        begin
            int n = 0;
            for (int k = 0; k < 7; k++) n += int'(rec[k].srch_en);
            check("srch_en_count", n, 1);
        end
        check("srch_en_k2", rec[2].srch_en, 1'b1);
        check("srch_done_k4", rec[4].op_done, 1'b1);
        check("srch_csr_we_k4", rec[4].csr_we, 1'b1);
        check("srch_csr_op_k4", rec[4].csr_op, 3'd1);
        check("srch_found_k4", rec[4].csr_found, 1'b1);
        check("srch_index_k4", rec[4].csr_index, 5'd5);
        srch_finish = 1'b0; srch_found = 1'b0; srch_index = '0;
        wait_idle();

        // WR through DRAIN: busy for k=0..2, strobe one cycle after busy falls.
        run_op(3'd3, 3, -1, 8);
        begin
            int n = 0;
            bit blk = 1'b1;
            for (int k = 0; k < 8; k++) n += int'(rec[k].tlb_wen);
            for (int k = 1; k <= 4; k++) blk &= rec[k].trans_block;
            check("wr_wen_count", n, 1);
            check("wr_block_drain", blk, 1'b1);
        end
        check("wr_wen_k4", rec[4].tlb_wen, 1'b1);
        check("wr_done_k5", rec[5].op_done, 1'b1);
        wait_idle();

        // FILL across the counter wrap: index 29 at accept, 31 in EXEC.
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(negedge clk);
                hit = (rand_index == 5'd28);
            end
            check("fill_sync", hit, 1'b1);
        end
        run_op(3'd4, 0, -1, 6);
        check("fill_en_k2", rec[2].fill_en, 1'b1);
        check("fill_idx_k2", rec[2].rand_index, 5'd31);
        check("fill_idx_k3", rec[3].rand_index, 5'd31);
        check("fill_idx_k4", rec[4].rand_index, 5'd0);
        check("fill_idx_k5", rec[5].rand_index, 5'd1);
        wait_idle();

        // INVTLB with specific operands.
        inv_op_i = 5'd5; inv_asid_i = 10'h3A; inv_vpn_i = 19'h1234;
        run_op(3'd5, 0, -1, 6);
        check("inv_en_k2", rec[2].tlbinv_en, 1'b1);
        check("inv_en_k3", rec[3].tlbinv_en, 1'b0);
        check("inv_op_k2", rec[2].inv_op, 5'd5);
        check("inv_asid_k2", rec[2].inv_asid, 10'h3A);
        check("inv_vpn_k2", rec[2].inv_vpn, 19'h1234);
        check("inv_done_k3", rec[3].op_done, 1'b1);
        wait_idle();

        // Flush while waiting on search result.
        run_op(3'd1, 0, 3, 8);
        begin
            int nd = 0, nw = 0;
            for (int k = 0; k < 8; k++) begin
                nd += int'(rec[k].op_done);
                nw += int'(rec[k].csr_we);
            end
            check("flush_no_done", nd, 0);
            check("flush_no_csr_we", nw, 0);
        end
        check("flush_ready_k4", rec[4].op_ready, 1'b1);
        check("flush_block_k4", rec[4].trans_block, 1'b0);
        wait_idle();

        // Illegal op: immediate completion, nothing else.
        run_op(3'd7, 0, -1, 4);
        begin
            int ns = 0, nb = 0;
            for (int k = 0; k < 4; k++) begin
                ns += int'(rec[k].srch_en) + int'(rec[k].tlb_wen) + int'(rec[k].fill_en) +
                      int'(rec[k].tlbinv_en) + int'(rec[k].csr_we);
                nb += int'(rec[k].trans_block);
            end
            check("illegal_strobes", ns, 0);
            check("illegal_block", nb, 0);
        end
        check("illegal_done_k1", rec[1].op_done, 1'b1);
        wait_idle();

        // Randomized traffic, including flushes and mid-op resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            op_valid    = ($urandom_range(0, 9) < 4);
            op_type     = 3'($urandom_range(0, 7));
            inv_op_i    = 5'($urandom);
            inv_asid_i  = 10'($urandom);
            inv_vpn_i   = 19'($urandom);
            trans_busy  = ($urandom_range(0, 1) == 1);
            srch_finish = ($urandom_range(0, 9) < 4);
            srch_found  = ($urandom_range(0, 1) == 1);
            srch_index  = 5'($urandom);
            excp_flush  = ($urandom_range(0, 99) < 3);
            ertn_flush  = ($urandom_range(0, 99) < 3);
            reset       = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #1;
        op_valid = 1'b0; trans_busy = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0; reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
